// File: rtl/fp_add_scheduler.sv
// fp_add_scheduler: round-robin front end that shares one fixed-latency,
// non-stallable floating-point adder between NUM_REQ requesters. Results are
// tagged with the requester ID and returned in issue order through a response
// FIFO. Credits (in_flight + count) keep the adder from overrunning the FIFO.

// Format codes and width lookup, used when no project format header is present.
`ifndef FP32
`define FP32 0
`endif
`ifndef GET_FP_LEN
`define GET_FP_LEN(fmt) (((fmt) == 1) ? 64 : (((fmt) == 2) ? 16 : 32))
`endif

module fp_add_scheduler #(
  parameter int data_format = `FP32,
  parameter int NUM_REQ     = 4,
  parameter int LATENCY     = 3,
  parameter int RESP_DEPTH  = 8,
  localparam int FP_LEN     = `GET_FP_LEN(data_format),
  localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*FP_LEN-1:0] req_a,
  input  logic [NUM_REQ*FP_LEN-1:0] req_b,
  output logic                      add_valid,
  output logic [FP_LEN-1:0]         add_a,
  output logic [FP_LEN-1:0]         add_b,
  input  logic [FP_LEN-1:0]         add_res,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [FP_LEN-1:0]         resp_data,
  output logic [ID_W-1:0]           resp_id,
  output logic                      busy
);

  localparam int CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(RESP_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RESP_DEPTH - 1);
  localparam logic [ID_W-1:0]  RR_INIT  = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0]   rr_ptr_q;
  logic              add_valid_q;
  logic [FP_LEN-1:0] add_a_q, add_b_q;
  logic [ID_W-1:0]   issue_id_q;
  logic              tag_v_q  [LATENCY];
  logic [ID_W-1:0]   tag_id_q [LATENCY];
  logic [FP_LEN-1:0] mem_data_q [RESP_DEPTH];
  logic [ID_W-1:0]   mem_id_q   [RESP_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  in_flight_q, in_flight_d;

  logic              can_issue;
  logic              found;
  logic              handshake;
  int                idx;
  int                grant_int;
  logic              wr_en;
  logic              pop;

  // Credit check uses registered counts only, so a pop frees its slot one cycle later.
  assign can_issue = ({1'b0, in_flight_q} + {1'b0, count_q}) < DEPTH_C;
  assign handshake = found && can_issue;
  assign wr_en     = tag_v_q[LATENCY-1];
  assign pop       = resp_valid && resp_ready;

  // Round-robin pick: first valid requester searching from rr_ptr+1 upwards.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves a latch.
    req_ready = '0;
    found     = 1'b0;
    grant_int = 0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found     = 1'b1;
        grant_int = idx;
      end
    end
    if (found && can_issue) req_ready[grant_int] = 1'b1;
  end

  // Issue register: capture the granted operand pair and remember whose it is.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is written with non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      add_valid_q <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      issue_id_q  <= '0;
      rr_ptr_q    <= RR_INIT;
    end else begin
      add_valid_q <= handshake;
      if (handshake) begin
        add_a_q    <= req_a[grant_int*FP_LEN +: FP_LEN];
        add_b_q    <= req_b[grant_int*FP_LEN +: FP_LEN];
        issue_id_q <= ID_W'(grant_int);
        rr_ptr_q   <= ID_W'(grant_int);
      end
    end
  end

  // Tag pipe: shadows the adder so the tail marks the cycle add_res is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        tag_v_q[i]  <= 1'b0;
        tag_id_q[i] <= '0;
      end
    end else begin
      tag_v_q[0]  <= add_valid_q;
      tag_id_q[0] <= issue_id_q;
      for (int i = 1; i < LATENCY; i++) begin
        tag_v_q[i]  <= tag_v_q[i-1];
        tag_id_q[i] <= tag_id_q[i-1];
      end
    end
  end

  // Response storage: write adder result and its tag at the FIFO tail.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: storage is cleared on reset so resp_data reads zero before the first write.
    if (!rst_n) begin
      for (int i = 0; i < RESP_DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_id_q[i]   <= '0;
      end
    end else if (wr_en) begin
      mem_data_q[wr_ptr_q] <= add_res;
      mem_id_q[wr_ptr_q]   <= tag_id_q[LATENCY-1];
    end
  end

  // Next-state for occupancy and outstanding-issue counters.
  always_comb begin
    count_d     = count_q;
    in_flight_d = in_flight_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    case ({handshake, wr_en})
      2'b10:   in_flight_d = in_flight_q + CNT_W'(1);
      2'b01:   in_flight_d = in_flight_q - CNT_W'(1);
      default: in_flight_d = in_flight_q;
    endcase
  end

  // Pointer and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_flight_q <= '0;
    end else begin
      count_q     <= count_d;
      in_flight_q <= in_flight_d;
      if (wr_en) wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      if (pop)   rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    end
  end

  assign add_valid  = add_valid_q;
  assign add_a      = add_a_q;
  assign add_b      = add_b_q;
  assign resp_valid = (count_q != '0);
  assign resp_data  = mem_data_q[rd_ptr_q];
  assign resp_id    = mem_id_q[rd_ptr_q];
  assign busy       = (in_flight_q != '0) || (count_q != '0);

  // The credit rule must make a write into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    wr_en |-> (count_q < CNT_W'(RESP_DEPTH)));

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Testbench for fp_add_scheduler: a behavioural fixed-latency adder, a
// scoreboard of expected (id, result) pairs filled at each handshake and
// drained at each response pop, and one task per scenario.
`timescale 1ns/1ps

module tb_fp_add_scheduler;

  localparam int NUM_REQ    = 4;
  localparam int LATENCY    = 3;
  localparam int RESP_DEPTH = 8;
  localparam int FP_LEN     = 32;
  localparam int ID_W       = 2;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*FP_LEN-1:0] req_a;
  logic [NUM_REQ*FP_LEN-1:0] req_b;
  logic                      add_valid;
  logic [FP_LEN-1:0]         add_a;
  logic [FP_LEN-1:0]         add_b;
  logic [FP_LEN-1:0]         add_res;
  logic                      resp_valid;
  logic                      resp_ready;
  logic [FP_LEN-1:0]         resp_data;
  logic [ID_W-1:0]           resp_id;
  logic                      busy;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [FP_LEN-1:0] data;
  } exp_t;

  exp_t               exp_q[$];
  int                 n_tests;
  int                 n_fail;
  logic [NUM_REQ-1:0] last_hs;

  fp_add_scheduler #(
    .NUM_REQ    (NUM_REQ),
    .LATENCY    (LATENCY),
    .RESP_DEPTH (RESP_DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .add_valid  (add_valid),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_res    (add_res),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in adder: exact for 1.0+2.0, an asymmetric mix otherwise so swapped
  // or misrouted operands show up in the results.
  function automatic logic [FP_LEN-1:0] fp_model(input logic [FP_LEN-1:0] a,
                                                 input logic [FP_LEN-1:0] b);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return a + {b[30:0], b[31]};
  endfunction

  logic [FP_LEN-1:0] add_pipe [LATENCY];
  always @(posedge clk) begin
    add_pipe[0] <= add_valid ? fp_model(add_a, add_b) : 32'hDEAD_BEEF;
    for (int i = 1; i < LATENCY; i++) add_pipe[i] <= add_pipe[i-1];
  end
  assign add_res = add_pipe[LATENCY-1];

  task automatic set_ops(input int i);
    req_a[i*FP_LEN +: FP_LEN] = $urandom();
    req_b[i*FP_LEN +: FP_LEN] = $urandom();
  endtask

  task automatic refresh_granted();
    for (int i = 0; i < NUM_REQ; i++) if (last_hs[i]) set_ops(i);
  endtask

  // One clock: at the falling edge record handshakes and score any pop, then
  // return 1 ns after the next rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    last_hs = '0;
    if (rst_n) begin
      n_tests++;
      if ($countones(req_ready) > 1) begin
        n_fail++;
        $display("FAIL grant_onehot: req_ready=%b, required one-hot or zero", req_ready);
      end
      last_hs = req_valid & req_ready;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (last_hs[i]) begin
          e.id   = ID_W'(i);
          e.data = fp_model(req_a[i*FP_LEN +: FP_LEN], req_b[i*FP_LEN +: FP_LEN]);
          exp_q.push_back(e);
        end
      end
      if (resp_valid && resp_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL resp_unexpected: got id=%0d data=%h, required no response", resp_id, resp_data);
        end else begin
          e = exp_q.pop_front();
          if (resp_data !== e.data || resp_id !== e.id) begin
            n_fail++;
            $display("FAIL resp_order: got id=%0d data=%h, required id=%0d data=%h",
                     resp_id, resp_data, e.id, e.data);
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    req_valid  = '0;
    resp_ready = 1'b1;
    for (int c = 0; c < 60 && busy; c++) cycle();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_timeout: busy=%b, required 0", busy);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_missing: %0d responses outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if (add_valid !== 1'b0 || add_a !== '0 || add_b !== '0 || resp_valid !== 1'b0 ||
        resp_data !== '0 || resp_id !== '0 || busy !== 1'b0 || req_ready !== '0) begin
      n_fail++;
      $display("FAIL reset_state: add_valid=%b add_a=%h resp_valid=%b resp_data=%h resp_id=%0d busy=%b req_ready=%b, required all zero",
               add_valid, add_a, resp_valid, resp_data, resp_id, busy, req_ready);
    end
  endtask

  task automatic test_single();
    logic exp_v;
    resp_ready = 1'b1;
    req_a[2*FP_LEN +: FP_LEN] = 32'h3F80_0000;
    req_b[2*FP_LEN +: FP_LEN] = 32'h4000_0000;
    req_valid = 4'b0100;
    #1;
    n_tests++;
    if (req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_ready: req_ready=%b, required 0100", req_ready);
    end
    cycle();
    req_valid = '0;
    n_tests++;
    if (add_valid !== 1'b1 || add_a !== 32'h3F80_0000 || add_b !== 32'h4000_0000 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_issue: add_valid=%b add_a=%h add_b=%h busy=%b, required 1 3f800000 40000000 1",
               add_valid, add_a, add_b, busy);
    end
    for (int k = 1; k <= LATENCY + 1; k++) begin
      cycle();
      exp_v = (k == LATENCY + 1);
      n_tests++;
      if (resp_valid !== exp_v) begin
        n_fail++;
        $display("FAIL single_latency: cycle %0d resp_valid=%b, required %b", k, resp_valid, exp_v);
      end
      if (k == 1) begin
        n_tests++;
        if (add_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL single_strobe: add_valid=%b, required 0", add_valid);
        end
      end
    end
    n_tests++;
    if (resp_data !== 32'h4040_0000 || resp_id !== 2'd2) begin
      n_fail++;
      $display("FAIL single_result: data=%h id=%0d, required 40400000 id 2", resp_data, resp_id);
    end
    cycle();
    n_tests++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: resp_valid=%b busy=%b, required 0 0", resp_valid, busy);
    end
  endtask

  task automatic test_round_robin();
    int                 prev;
    int                 want;
    logic               seen;
    logic [NUM_REQ-1:0] exp_hs;
    prev = 2;
    seen = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_ops(i);
    req_valid  = '1;
    resp_ready = 1'b1;
    for (int c = 0; c < 24; c++) begin
      cycle();
      want   = (prev + 1) % NUM_REQ;
      exp_hs = '0;
      exp_hs[want] = 1'b1;
      n_tests++;
      if (last_hs !== exp_hs) begin
        n_fail++;
        $display("FAIL rr_grant: cycle %0d handshake=%b, required %b", c, last_hs, exp_hs);
      end
      prev = want;
      refresh_granted();
      if (seen) begin
        n_tests++;
        if (resp_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL rr_bubble: cycle %0d resp_valid=%b, required 1", c, resp_valid);
        end
      end
      if (resp_valid) seen = 1'b1;
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int grants;
    int idle;
    grants = 0;
    idle   = 0;
    for (int i = 0; i < NUM_REQ; i++) set_ops(i);
    req_valid  = '1;
    resp_ready = 1'b0;
    for (int c = 0; c < 40 && idle < 6; c++) begin
      cycle();
      if (last_hs != '0) begin
        grants++;
        idle = 0;
      end else begin
        idle++;
      end
      refresh_granted();
    end
    n_tests++;
    if (grants != RESP_DEPTH) begin
      n_fail++;
      $display("FAIL bp_grants: %0d grants, required %0d", grants, RESP_DEPTH);
    end
    n_tests++;
    if (req_ready !== '0 || resp_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_full: req_ready=%b resp_valid=%b busy=%b, required 0000 1 1",
               req_ready, resp_valid, busy);
    end
    // One pop; the freed credit is visible only on the following cycle.
    resp_ready = 1'b1;
    cycle();
    resp_ready = 1'b0;
    n_tests++;
    if (last_hs !== '0) begin
      n_fail++;
      $display("FAIL bp_same_cycle: handshake=%b during pop, required 0000", last_hs);
    end
    n_tests++;
    if (req_ready === '0) begin
      n_fail++;
      $display("FAIL bp_regrant_ready: req_ready=%b after pop, required nonzero", req_ready);
    end
    cycle();
    refresh_granted();
    n_tests++;
    if ($countones(last_hs) != 1) begin
      n_fail++;
      $display("FAIL bp_regrant: handshake=%b, required exactly one", last_hs);
    end
    grants = 0;
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (last_hs != '0) grants++;
    end
    n_tests++;
    if (grants != 0) begin
      n_fail++;
      $display("FAIL bp_refull: %0d extra grants, required 0", grants);
    end
    // Stream from the nearly-full state: write and pop coincide every cycle.
    resp_ready = 1'b1;
    for (int c = 0; c < 24; c++) begin
      cycle();
      refresh_granted();
      n_tests++;
      if (resp_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_valid: cycle %0d resp_valid=%b, required 1", c, resp_valid);
      end
    end
    drain();
  endtask

  task automatic test_two_requesters();
    int                 want;
    logic [NUM_REQ-1:0] exp_hs;
    set_ops(1);
    set_ops(3);
    resp_ready = 1'b1;
    req_valid  = 4'b0010;
    #1;
    n_tests++;
    if (req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL two_setup: req_ready=%b, required 0010", req_ready);
    end
    cycle();
    refresh_granted();
    req_valid = 4'b1010;
    #1;
    n_tests++;
    if (req_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL two_priority: req_ready=%b, required 1000", req_ready);
    end
    want = 3;
    for (int c = 0; c < 8; c++) begin
      cycle();
      exp_hs = '0;
      exp_hs[want] = 1'b1;
      n_tests++;
      if (last_hs !== exp_hs) begin
        n_fail++;
        $display("FAIL two_alternate: cycle %0d handshake=%b, required %b", c, last_hs, exp_hs);
      end
      refresh_granted();
      want = (want == 3) ? 1 : 3;
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int grants;
    grants = 0;
    for (int i = 0; i < NUM_REQ; i++) set_ops(i);
    req_valid  = '1;
    resp_ready = 1'b0;
    for (int c = 0; c < 20 && grants < 5; c++) begin
      cycle();
      if (last_hs != '0) grants++;
      refresh_granted();
    end
    req_valid = '0;
    cycle();
    n_tests++;
    if (resp_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_setup: resp_valid=%b busy=%b, required 1 1", resp_valid, busy);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (add_valid !== 1'b0 || add_a !== '0 || resp_valid !== 1'b0 || resp_data !== '0 ||
        resp_id !== '0 || busy !== 1'b0 || req_ready !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: add_valid=%b add_a=%h resp_valid=%b resp_data=%h resp_id=%0d busy=%b req_ready=%b, required all zero",
               add_valid, add_a, resp_valid, resp_data, resp_id, busy, req_ready);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    req_valid = '1;
    #1;
    n_tests++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL mid_rr_reset: req_ready=%b, required 0001", req_ready);
    end
    req_valid  = '0;
    resp_ready = 1'b1;
    for (int c = 0; c < LATENCY + 4; c++) begin
      cycle();
      n_tests++;
      if (resp_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_stale: cycle %0d resp_valid=%b busy=%b, required 0 0", c, resp_valid, busy);
      end
    end
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    last_hs    = '0;
    rst_n      = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_two_requesters();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded 200000 ns, required completion");
    $fatal(1, "timeout");
  end

endmodule
